// File: rtl/upload_packer.sv
// upload_packer: transmit-side framer for the host link.
// Buffers one handler upload stream, then emits it as
//   HDR0, HDR1, SRC, LEN_H, LEN_L, payload[0..LEN-1], CSUM
// where CSUM = (SRC + LEN_H + LEN_L + sum(payload)) mod 256.
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   upload_req/_data/_source      handler stream request, byte, source ID
//   upload_valid / upload_ready   handler-side handshake (ready is comb from state/count)
//   usb_upload_data/_valid        framed output byte (registered)
//   usb_upload_ready              uplink consumes the byte this cycle
//   busy                          high whenever not IDLE
module upload_packer #(
  parameter int unsigned MAX_PAYLOAD = 64,
  parameter int unsigned ADDR_W      = $clog2(MAX_PAYLOAD),
  parameter logic [7:0]  HDR0        = 8'hAA,
  parameter logic [7:0]  HDR1        = 8'h55
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       upload_req,
  input  logic [7:0] upload_data,
  input  logic [7:0] upload_source,
  input  logic       upload_valid,
  output logic       upload_ready,
  output logic [7:0] usb_upload_data,
  output logic       usb_upload_valid,
  input  logic       usb_upload_ready,
  output logic       busy
);

  // count must reach MAX_PAYLOAD itself, hence one extra bit
  localparam int unsigned CNT_W = ADDR_W + 1;

  localparam logic [3:0] IDLE    = 4'd0;
  localparam logic [3:0] COLLECT = 4'd1;
  localparam logic [3:0] S_HDR0  = 4'd2;
  localparam logic [3:0] S_HDR1  = 4'd3;
  localparam logic [3:0] S_SRC   = 4'd4;
  localparam logic [3:0] S_LENH  = 4'd5;
  localparam logic [3:0] S_LENL  = 4'd6;
  localparam logic [3:0] S_PAY   = 4'd7;
  localparam logic [3:0] S_CSUM  = 4'd8;

  logic [3:0]        state, state_nxt;
  logic [7:0]        source_q, source_nxt;
  logic [CNT_W-1:0]  count, count_nxt, count_inc;
  logic [7:0]        checksum, checksum_nxt;
  logic [ADDR_W-1:0] rd_ptr, rd_ptr_nxt;
  logic [7:0]        mem [MAX_PAYLOAD];
  logic              wr_en;
  logic              accept;
  logic              emit_hs;
  logic              emit_hold;
  logic              emit_nxt;
  logic [7:0]        byte_nxt;
  logic [15:0]       len_nxt;

  assign upload_ready = (state == COLLECT) && (count < CNT_W'(MAX_PAYLOAD));
  assign accept       = upload_valid & upload_ready;
  assign emit_hs      = usb_upload_valid & usb_upload_ready;
  assign emit_hold    = usb_upload_valid & ~usb_upload_ready;
  assign count_inc    = count + CNT_W'(1);
  assign busy         = (state != IDLE);

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      source_q <= 8'h00;
      count    <= '0;
      checksum <= 8'h00;
      rd_ptr   <= '0;
    end else begin
      state    <= state_nxt;
      source_q <= source_nxt;
      count    <= count_nxt;
      checksum <= checksum_nxt;
      rd_ptr   <= rd_ptr_nxt;
    end
  end

  // Payload buffer, no reset needed
  always_ff @(posedge clk) begin
    if (wr_en) mem[count[ADDR_W-1:0]] <= upload_data;
  end

  // Next-state and datapath update
  always_comb begin
    state_nxt    = state;
    source_nxt   = source_q;
    count_nxt    = count;
    checksum_nxt = checksum;
    rd_ptr_nxt   = rd_ptr;
    wr_en        = 1'b0;
    case (state)
      IDLE: begin
        if (upload_req) begin
          source_nxt   = upload_source;
          count_nxt    = '0;
          checksum_nxt = upload_source;
          state_nxt    = COLLECT;
        end
      end
      COLLECT: begin
        if (accept) begin
          wr_en        = 1'b1;
          count_nxt    = count_inc;
          checksum_nxt = checksum + upload_data;
        end
        // a byte accepted as req falls still belongs to this frame
        if (count_nxt == CNT_W'(MAX_PAYLOAD)) begin
          state_nxt = S_HDR0;
        end else if (!upload_req) begin
          state_nxt = (count_nxt != '0) ? S_HDR0 : IDLE;
        end
      end
      S_HDR0: if (emit_hs) state_nxt = S_HDR1;
      S_HDR1: if (emit_hs) state_nxt = S_SRC;
      S_SRC:  if (emit_hs) state_nxt = S_LENH;
      S_LENH: begin
        if (emit_hs) begin
          checksum_nxt = checksum + len_nxt[15:8];
          state_nxt    = S_LENL;
        end
      end
      S_LENL: begin
        if (emit_hs) begin
          checksum_nxt = checksum + len_nxt[7:0];
          rd_ptr_nxt   = '0;
          state_nxt    = S_PAY;
        end
      end
      S_PAY: begin
        if (emit_hs) begin
          if (({1'b0, rd_ptr} + CNT_W'(1)) == count) begin
            state_nxt = S_CSUM;
          end else begin
            rd_ptr_nxt = rd_ptr + ADDR_W'(1);
          end
        end
      end
      S_CSUM: begin
        if (emit_hs) begin
          if (upload_req) begin
            // continuation frame after a full-buffer flush
            source_nxt   = upload_source;
            count_nxt    = '0;
            checksum_nxt = upload_source;
            state_nxt    = COLLECT;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign len_nxt = 16'(count_nxt);

  // Byte for the upcoming state; payload read is prefetched via rd_ptr_nxt
  always_comb begin
    byte_nxt = 8'h00;
    emit_nxt = 1'b1;
    case (state_nxt)
      S_HDR0:  byte_nxt = HDR0;
      S_HDR1:  byte_nxt = HDR1;
      S_SRC:   byte_nxt = source_nxt;
      S_LENH:  byte_nxt = len_nxt[15:8];
      S_LENL:  byte_nxt = len_nxt[7:0];
      S_PAY:   byte_nxt = mem[rd_ptr_nxt];
      S_CSUM:  byte_nxt = checksum_nxt;
      default: emit_nxt = 1'b0;
    endcase
  end

  // Registered uplink outputs, frozen while the uplink stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      usb_upload_valid <= 1'b0;
      usb_upload_data  <= 8'h00;
    end else if (!emit_hold) begin
      usb_upload_valid <= emit_nxt;
      usb_upload_data  <= byte_nxt;
    end
  end

endmodule

// File: tb/tb_upload_packer.sv
// Testbench for upload_packer: directed frames from the test plan plus
// randomized streams checked against a frame-level reference model.
module tb_upload_packer;

  localparam int unsigned MAXP = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       upload_req = 1'b0;
  logic [7:0] upload_data = 8'h00;
  logic [7:0] upload_source = 8'h00;
  logic       upload_valid = 1'b0;
  logic       upload_ready;
  logic [7:0] usb_upload_data;
  logic       usb_upload_valid;
  logic       usb_upload_ready = 1'b0;
  logic       busy;

  int n_checks = 0;
  int n_pass = 0;
  int cycle = 0;
  int valid_cycles = 0;
  int ready_mode = 0;

  logic [7:0] stim_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];
  int         obs_cyc[$];

  upload_packer #(.MAX_PAYLOAD(MAXP)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .upload_req       (upload_req),
    .upload_data      (upload_data),
    .upload_source    (upload_source),
    .upload_valid     (upload_valid),
    .upload_ready     (upload_ready),
    .usb_upload_data  (usb_upload_data),
    .usb_upload_valid (usb_upload_valid),
    .usb_upload_ready (usb_upload_ready),
    .busy             (busy)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Uplink sink: drives usb_upload_ready, records consumed bytes, checks stalls
  initial begin : monitor
    bit         prev_stall;
    logic [7:0] prev_data;
    int         phase;
    bit         r;
    prev_stall = 1'b0;
    prev_data  = 8'h00;
    phase      = 0;
    forever begin
      @(negedge clk);
      cycle++;
      if (!rst_n) begin
        prev_stall       = 1'b0;
        usb_upload_ready = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_valid_held", int'(usb_upload_valid), 1);
          check("stall_data_held", int'(usb_upload_data), int'(prev_data));
        end
        if (usb_upload_valid) begin
          valid_cycles++;
          check("no_accept_while_emit", int'(upload_ready), 0);
        end
        case (ready_mode)
          0:       r = 1'b1;
          1: begin r = (phase % 4 == 0) || (phase % 4 == 3); phase++; end
          default: r = 1'($urandom_range(0, 1));
        endcase
        usb_upload_ready = r;
        if (usb_upload_valid && r) begin
          obs_q.push_back(usb_upload_data);
          obs_cyc.push_back(cycle);
        end
        prev_stall = usb_upload_valid && !r;
        prev_data  = usb_upload_data;
      end
    end
  end

  // Handler side: send stim_q as one request
  task automatic send_stream(input logic [7:0] src, input bit late,
                             input bit gaps, input bit src_change);
    int w;
    @(negedge clk);
    upload_source = src;
    upload_req    = 1'b1;
    upload_valid  = 1'b0;
    if (stim_q.size() == 0) repeat (3) @(negedge clk);
    foreach (stim_q[i]) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        upload_valid = 1'b0;
        @(negedge clk);
      end
      upload_valid = 1'b1;
      upload_data  = stim_q[i];
      w = 0;
      while (!upload_ready && w < 300) begin
        @(negedge clk);
        w++;
      end
      if (w >= 300) begin
        check("accept_timeout", w, 0);
        upload_valid = 1'b0;
        upload_req   = 1'b0;
        return;
      end
      if (late && i == stim_q.size() - 1) upload_req = 1'b0;
      @(negedge clk);
      if (src_change) upload_source = src ^ 8'hFF;
    end
    upload_valid = 1'b0;
    upload_req   = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int w;
    w = 0;
    repeat (2) @(negedge clk);
    while ((busy || usb_upload_valid) && w < 1000) begin
      @(negedge clk);
      w++;
    end
    if (w >= 1000) check({tag, "_idle_timeout"}, w, 0);
    @(negedge clk);
  endtask

  // Reference: stream split into MAXP-byte chunks, each framed independently
  task automatic build_model(input logic [7:0] src);
    int n, len, sum;
    exp_q.delete();
    n = stim_q.size();
    for (int base = 0; base < n; base += MAXP) begin
      len = (n - base < MAXP) ? n - base : MAXP;
      sum = src + (len / 256) + (len % 256);
      exp_q.push_back(8'hAA);
      exp_q.push_back(8'h55);
      exp_q.push_back(src);
      exp_q.push_back(8'(len / 256));
      exp_q.push_back(8'(len % 256));
      for (int k = 0; k < len; k++) begin
        exp_q.push_back(stim_q[base + k]);
        sum += stim_q[base + k];
      end
      exp_q.push_back(8'(sum % 256));
    end
  endtask

  task automatic compare_obs(input string tag);
    int n;
    check({tag, "_len"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s_b%0d", tag, i), int'(obs_q[i]), int'(exp_q[i]));
  endtask

  task automatic clear_obs();
    obs_q.delete();
    obs_cyc.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_usb_valid"}, int'(usb_upload_valid), 0);
    check({tag, "_usb_data"}, int'(usb_upload_data), 0);
    check({tag, "_upload_ready"}, int'(upload_ready), 0);
    check({tag, "_busy"}, int'(busy), 0);
  endtask

  initial begin : main
    int w;
    logic [7:0] src;
    int len;
    bit late, gaps;

    // reset values
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // basic frame, uplink always ready, must be gapless
    ready_mode = 0;
    clear_obs();
    stim_q = '{8'h11, 8'h22, 8'h33};
    send_stream(8'h01, 1'b0, 1'b0, 1'b0);
    wait_idle("basic");
    exp_q = '{8'hAA, 8'h55, 8'h01, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h6A};
    compare_obs("basic");
    if (obs_cyc.size() == 9) check("basic_gapless", obs_cyc[8] - obs_cyc[0], 8);
    check("basic_busy_low", int'(busy), 0);

    // full-buffer split into two frames with req held high
    clear_obs();
    stim_q = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    send_stream(8'h02, 1'b0, 1'b0, 1'b0);
    wait_idle("split");
    exp_q = '{8'hAA, 8'h55, 8'h02, 8'h00, 8'h04, 8'h00, 8'h01, 8'h02, 8'h03, 8'h0C,
              8'hAA, 8'h55, 8'h02, 8'h00, 8'h02, 8'h04, 8'h05, 8'h0D};
    compare_obs("split");

    // output backpressure 1,0,0,1,...
    ready_mode = 1;
    clear_obs();
    stim_q = '{8'h11, 8'h22, 8'h33};
    send_stream(8'h01, 1'b0, 1'b0, 1'b0);
    wait_idle("bp");
    exp_q = '{8'hAA, 8'h55, 8'h01, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h6A};
    compare_obs("bp");

    // empty request is suppressed
    ready_mode = 0;
    clear_obs();
    valid_cycles = 0;
    stim_q.delete();
    send_stream(8'h09, 1'b0, 1'b0, 1'b0);
    wait_idle("empty");
    repeat (3) @(negedge clk);
    check("empty_no_valid", valid_cycles, 0);
    check("empty_busy_low", int'(busy), 0);

    // reset in the middle of payload emission
    clear_obs();
    stim_q = '{8'h10, 8'h20, 8'h30};
    send_stream(8'h07, 1'b1, 1'b0, 1'b0);
    w = 0;
    while (obs_q.size() < 6 && w < 200) begin
      @(negedge clk);
      w++;
    end
    check("midrst_reach_payload_timeout", int'(w >= 200), 0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    clear_obs();
    stim_q = '{8'hFF};
    send_stream(8'h05, 1'b0, 1'b0, 1'b0);
    wait_idle("postrst");
    exp_q = '{8'hAA, 8'h55, 8'h05, 8'h00, 8'h01, 8'hFF, 8'h05};
    compare_obs("postrst");

    // late byte as req falls, source changed after the latch
    ready_mode = 2;
    clear_obs();
    stim_q = '{8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))};
    send_stream(8'h33, 1'b1, 1'b0, 1'b1);
    wait_idle("late");
    build_model(8'h33);
    compare_obs("late");

    // randomized streams against the reference model
    for (int t = 0; t < 30; t++) begin
      ready_mode = $urandom_range(0, 2);
      src  = 8'($urandom_range(0, 255));
      len  = $urandom_range(0, 11);
      late = 1'($urandom_range(0, 1));
      gaps = 1'($urandom_range(0, 1));
      stim_q.delete();
      for (int k = 0; k < len; k++) stim_q.push_back(8'($urandom_range(0, 255)));
      clear_obs();
      send_stream(src, late, gaps, 1'b0);
      wait_idle($sformatf("rnd%0d", t));
      build_model(src);
      compare_obs($sformatf("rnd%0d", t));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
